// File: rtl/pulse_delay_pkg.sv
// Shared definitions for the programmable multi-channel pulse delay.
package pulse_delay_pkg;

  // Per-channel FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PULSE = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_delay_multi_if.sv
// Bundles the per-channel trigger/control inputs and pulse/status outputs.
interface pulse_delay_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int WID_W    = 4
);

  logic [CHANNELS-1:0]       trig;
  logic [CHANNELS*CNT_W-1:0] delay;
  logic [CHANNELS*WID_W-1:0] width;
  logic [CHANNELS-1:0]       retrig;
  logic [CHANNELS-1:0]       cancel;
  logic [CHANNELS-1:0]       out;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS-1:0]       overrun;

  // Side that requests pulses and observes them.
  modport master (
    output trig, delay, width, retrig, cancel,
    input  out, busy, overrun
  );

  // The pulse generator itself.
  modport slave (
    input  trig, delay, width, retrig, cancel,
    output out, busy, overrun
  );

endinterface

// File: rtl/pulse_delay_chan.sv
// One delay channel: edge-detect trig, count down delay, then emit a pulse
// of the latched width. Supports retrigger, cancel and overrun reporting.
module pulse_delay_chan
  import pulse_delay_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int WID_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [CNT_W-1:0] delay,
  input  logic [WID_W-1:0] width,
  input  logic             retrig,
  input  logic             cancel,
  output logic             out,
  output logic             busy,
  output logic             overrun
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [WID_W-1:0] wlat_q, wlat_d;
  logic [WID_W-1:0] wcnt_q, wcnt_d;
  logic             out_d, busy_d, overrun_d;
  logic             trig_q;
  logic             rise;

  assign rise = trig & ~trig_q;

  // Trigger history register for edge detection.
  // NOTE: trig_q tracks trig even while reset is asserted, so a trigger that
  // is already high when reset releases is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    trig_q <= trig;
  end

  // State and output registers; synchronous reset returns the channel to idle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      wlat_q  <= '0;
      wcnt_q  <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      wlat_q  <= wlat_d;
      wcnt_q  <= wcnt_d;
      out     <= out_d;
      busy    <= busy_d;
      overrun <= overrun_d;
    end
  end

  // Next-state logic: cancel first, then accept/retrigger/ignore edges,
  // then the normal delay and width countdowns.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statements can leave one unassigned and infer a latch.
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    wlat_d    = wlat_q;
    wcnt_d    = wcnt_q;
    out_d     = out;
    busy_d    = busy;
    overrun_d = 1'b0;

    if (cancel) begin
      // A simultaneous rise is dropped silently.
      state_d = ST_IDLE;
      out_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_COUNT;
            dcnt_d  = delay;
            wlat_d  = width;
            busy_d  = 1'b1;
            out_d   = 1'b0;
          end
        end

        ST_COUNT: begin
          if (rise && retrig) begin
            dcnt_d = delay;
            wlat_d = width;
            out_d  = 1'b0;
          end else begin
            overrun_d = rise;
            if (dcnt_q == '0) begin
              state_d = ST_PULSE;
              out_d   = 1'b1;
              // A zero width is stretched to a single cycle.
              wcnt_d  = (wlat_q == '0) ? '0 : wlat_q - WID_W'(1);
            end else begin
              dcnt_d = dcnt_q - CNT_W'(1);
            end
          end
        end

        ST_PULSE: begin
          if (rise && retrig) begin
            state_d = ST_COUNT;
            dcnt_d  = delay;
            wlat_d  = width;
            out_d   = 1'b0;
          end else begin
            overrun_d = rise;
            if (wcnt_q == '0) begin
              state_d = ST_IDLE;
              out_d   = 1'b0;
              busy_d  = 1'b0;
            end else begin
              wcnt_d = wcnt_q - WID_W'(1);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          out_d   = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_delay_multi.sv
// Multi-channel programmable pulse delay: independent channels that only
// share the clock and reset; this level just slices the packed buses.
module pulse_delay_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int WID_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  pulse_delay_multi_if.slave bus
);

  // One delay channel per trigger bit.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pulse_delay_chan #(
      .CNT_W (CNT_W),
      .WID_W (WID_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .trig    (bus.trig[i]),
      .delay   (bus.delay[i*CNT_W +: CNT_W]),
      .width   (bus.width[i*WID_W +: WID_W]),
      .retrig  (bus.retrig[i]),
      .cancel  (bus.cancel[i]),
      .out     (bus.out[i]),
      .busy    (bus.busy[i]),
      .overrun (bus.overrun[i])
    );
  end

endmodule

// File: tb/tb_pulse_delay_multi.sv
// Self-checking bench for pulse_delay_multi: directed scenarios followed by
// randomized traffic, all checked against a timestamp-based reference model.
module tb_pulse_delay_multi;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pulse_delay_multi_if #(.CHANNELS(CH), .CNT_W(CW), .WID_W(WW)) bus ();

  pulse_delay_multi #(.CHANNELS(CH), .CNT_W(CW), .WID_W(WW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each accepted trigger at edge n fixes the window of
  // edges after which out is high, [n+d+1, n+d+max(w,1)].
  int edge_n = 0;
  int m_first [CH];
  int m_last  [CH];
  bit m_act   [CH];
  bit m_tq    [CH];
  bit m_ovr   [CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_edge();
    edge_n++;
    for (int c = 0; c < CH; c++) begin
      bit rise;
      bit busy_before;
      int d;
      int w;
      rise     = bus.trig[c] && !m_tq[c];
      m_tq[c]  = bus.trig[c];
      m_ovr[c] = 1'b0;
      busy_before = m_act[c] && (edge_n - 1 <= m_last[c]);
      if (reset) begin
        m_act[c] = 1'b0;
      end else if (bus.cancel[c]) begin
        m_act[c] = 1'b0;
      end else if (rise) begin
        if (busy_before && !bus.retrig[c]) begin
          m_ovr[c] = 1'b1;
        end else begin
          d = int'(bus.delay[c*CW +: CW]);
          w = int'(bus.width[c*WW +: WW]);
          if (w == 0) w = 1;
          m_act[c]   = 1'b1;
          m_first[c] = edge_n + d + 1;
          m_last[c]  = edge_n + d + w;
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared at the negedge.
  task automatic step();
    logic [CH-1:0] e_out, e_busy, e_ovr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      e_busy[c] = m_act[c] && (edge_n <= m_last[c]);
      e_out[c]  = m_act[c] && (edge_n >= m_first[c]) && (edge_n <= m_last[c]);
      e_ovr[c]  = m_ovr[c];
    end
    check("out",     32'(bus.out),     32'(e_out));
    check("busy",    32'(bus.busy),    32'(e_busy));
    check("overrun", 32'(bus.overrun), 32'(e_ovr));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic set_ch(input int c, input int d, input int w, input bit r);
    logic [31:0] dv;
    logic [31:0] wv;
    dv = d;
    wv = w;
    bus.delay[c*CW +: CW] = dv[CW-1:0];
    bus.width[c*WW +: WW] = wv[WW-1:0];
    bus.retrig[c]         = r;
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_act[c] = 0; m_tq[c] = 0; m_ovr[c] = 0; m_first[c] = 0; m_last[c] = 0;
    end
    reset      = 1'b1;
    bus.trig   = '0;
    bus.delay  = '0;
    bus.width  = '0;
    bus.retrig = '0;
    bus.cancel = '0;
    run(3);
    check("reset_out",  32'(bus.out), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    run(2);

    // 1: delay 3, width 2 -> high after rise+4 and rise+5.
    set_ch(0, 3, 2, 0);
    bus.trig[0] = 1'b1;
    step();
    bus.trig[0] = 1'b0;
    run(3);
    check("t1_early",  32'(bus.out[0]), 32'd0);
    check("t1_busy",   32'(bus.busy[0]), 32'd1);
    step();
    check("t1_first",  32'(bus.out[0]), 32'd1);
    step();
    check("t1_second", 32'(bus.out[0]), 32'd1);
    step();
    check("t1_end",    32'(bus.out[0]), 32'd0);
    check("t1_idle",   32'(bus.busy[0]), 32'd0);
    run(2);

    // 2: delay 0, width 0 -> one-cycle pulse after rise+1; held trig no refire.
    set_ch(1, 0, 0, 0);
    bus.trig[1] = 1'b1;
    step();
    check("t2_lat0", 32'(bus.out[1]), 32'd0);
    step();
    check("t2_pulse", 32'(bus.out[1]), 32'd1);
    step();
    check("t2_one", 32'(bus.out[1]), 32'd0);
    run(20);
    bus.trig[1] = 1'b0;
    run(2);

    // 3: overrun on ignored rise, then retrigger with no overrun.
    for (int r = 0; r < 2; r++) begin
      set_ch(2, 10, 1, r[0]);
      bus.trig[2] = 1'b1;
      step();
      bus.trig[2] = 1'b0;
      run(3);
      bus.trig[2] = 1'b1;
      step();
      check("t3_ovr", 32'(bus.overrun[2]), (r == 0) ? 32'd1 : 32'd0);
      bus.trig[2] = 1'b0;
      step();
      check("t3_ovr_once", 32'(bus.overrun[2]), 32'd0);
      run(20);
    end

    // 4: cancel in the 2nd pulse cycle, then cancel coincident with a rise.
    set_ch(3, 5, 4, 0);
    bus.trig[3] = 1'b1;
    step();
    bus.trig[3] = 1'b0;
    run(7);
    check("t4_pulse2", 32'(bus.out[3]), 32'd1);
    bus.cancel[3] = 1'b1;
    step();
    check("t4_cancel_out",  32'(bus.out[3]), 32'd0);
    check("t4_cancel_busy", 32'(bus.busy[3]), 32'd0);
    bus.cancel[3] = 1'b0;
    run(2);
    bus.cancel[3] = 1'b1;
    bus.trig[3]   = 1'b1;
    step();
    bus.cancel[3] = 1'b0;
    run(12);
    bus.trig[3] = 1'b0;
    run(2);

    // 5: all channels on one edge, staggered delays.
    for (int c = 0; c < CH; c++) set_ch(c, c + 1, 1, 0);
    bus.trig = '1;
    step();
    bus.trig = '0;
    run(8);

    // 6: reset mid-COUNT (ch0) and mid-PULSE (ch1) with trig held high.
    set_ch(0, 20, 3, 0);
    set_ch(1, 1, 8, 0);
    bus.trig[1:0] = 2'b11;
    run(4);
    check("t6_ch1_pulse", 32'(bus.out[1]), 32'd1);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(30);
    bus.trig[1:0] = 2'b00;
    run(2);
    bus.trig[1:0] = 2'b11;
    run(30);
    bus.trig = '0;
    run(2);

    // Randomized traffic on all channels.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(3, 0) == 0) bus.trig[c] = ~bus.trig[c];
        set_ch(c, ($urandom_range(31, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(12, 0),
               $urandom_range(15, 0), $urandom_range(1, 0) == 1);
        bus.cancel[c] = ($urandom_range(39, 0) == 0);
      end
      reset = ($urandom_range(299, 0) == 0);
      step();
    end
    reset = 1'b0;
    bus.cancel = '0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
